// File: rtl/MD_pkg.sv
// Shared types and constants for the MD position network interface.
// Build option NI_POS_SKID_EN selects the two-entry skid slice instead of a single pipeline register.
package MD_pkg;

  localparam int NI_AXIS_TDATA_WIDTH      = 512;
  localparam int NI_STREAMING_TDEST_WIDTH = 16;
  localparam int NI_PKT_CNT_WIDTH         = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ni_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// AXI-Stream register slice; NI_POS_SKID_EN adds a skid entry so in_rdy is a pure register.
// Latency: 1 cycle. Backpressure: skid build holds one extra beat; default build passes out_rdy through to in_rdy.
// en gates acceptance only; buffered beats always drain.
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic in_fire;

`ifdef NI_POS_SKID_EN
  logic [W-1:0] skid_dat;
  logic         skid_vld;

  assign in_rdy  = en & ~skid_vld;
  assign in_fire = in_vld & in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_dat  <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
    end else if (~out_vld | out_rdy) begin
      // Output slot frees up: the skid entry is older than anything arriving now
      if (skid_vld) begin
        out_dat  <= skid_dat;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= in_fire;
        if (in_fire) out_dat <= in_dat;
      end
    end else if (in_fire) begin
      skid_dat <= in_dat;
      skid_vld <= 1'b1;
    end
  end
`else
  assign in_rdy  = en & (~out_vld | out_rdy);
  assign in_fire = in_vld & in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (in_fire) begin
      out_dat <= in_dat;
      out_vld <= 1'b1;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/network_interface_pos.sv
// Position-stream pass-through with packet-count completion (ap_start/ap_idle/ap_done); option NI_POS_SKID_EN.
// Latency: 1 cycle inbound to outbound. Backpressure: M tready stalls the slice, which drops S tready.
// Inbound accepted only in RUN; the slice keeps draining in every state.
module network_interface_pos
  import MD_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH      = NI_AXIS_TDATA_WIDTH,
  parameter int STREAMING_TDEST_WIDTH = NI_STREAMING_TDEST_WIDTH
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst,
  input  logic [AXIS_TDATA_WIDTH-1:0]        S_AXIS_n2k_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0]      S_AXIS_n2k_tkeep,
  input  logic                               S_AXIS_n2k_tvalid,
  input  logic                               S_AXIS_n2k_tlast,
  input  logic [STREAMING_TDEST_WIDTH-1:0]   S_AXIS_n2k_tdest,
  output logic                               S_AXIS_n2k_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]        M_AXIS_k2n_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0]      M_AXIS_k2n_tkeep,
  output logic                               M_AXIS_k2n_tvalid,
  output logic                               M_AXIS_k2n_tlast,
  output logic [STREAMING_TDEST_WIDTH-1:0]   M_AXIS_k2n_tdest,
  input  logic                               M_AXIS_k2n_tready,
  input  logic [NI_PKT_CNT_WIDTH-1:0]        number_packets,
  input  logic                               reset_fsm_n,
  input  logic                               ap_start,
  output logic                               ap_idle,
  output logic                               ap_done
);

  localparam int KW = AXIS_TDATA_WIDTH / 8;
  localparam int PW = AXIS_TDATA_WIDTH + KW + 1 + STREAMING_TDEST_WIDTH;

  ni_state_e                    state_q, state_d;
  logic [NI_PKT_CNT_WIDTH-1:0]  target_q, pkt_cnt, cnt_next;
  logic                         srst, run, cnt_inc, reached;
  logic [PW-1:0]                in_dat, out_dat;

  assign srst = ap_rst | ~reset_fsm_n;
  assign run  = (state_q == RUN);

  // Saturating count: no increment once the target is reached
  assign cnt_inc  = M_AXIS_k2n_tvalid & M_AXIS_k2n_tready & M_AXIS_k2n_tlast & (pkt_cnt != target_q);
  assign cnt_next = cnt_inc ? pkt_cnt + NI_PKT_CNT_WIDTH'(1) : pkt_cnt;
  // Looking at the post-transfer count lets ap_done follow the last tlast by one cycle
  assign reached  = (cnt_next == target_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ap_start) state_d = RUN;
      RUN:     if (reached) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (srst) begin
      state_q  <= IDLE;
      target_q <= '0;
      pkt_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ap_start) begin
        target_q <= number_packets;
        pkt_cnt  <= '0;
      end else begin
        pkt_cnt <= cnt_next;
      end
    end
  end

  assign ap_idle = (state_q == IDLE);
  assign ap_done = (state_q == DONE);

  assign in_dat = {S_AXIS_n2k_tdata, S_AXIS_n2k_tkeep, S_AXIS_n2k_tlast, S_AXIS_n2k_tdest};
  assign {M_AXIS_k2n_tdata, M_AXIS_k2n_tkeep, M_AXIS_k2n_tlast, M_AXIS_k2n_tdest} = out_dat;

  axis_reg_slice #(
    .W(PW)
  ) u_slice (
    .clk     (ap_clk),
    .rst     (srst),
    .en      (run),
    .in_dat  (in_dat),
    .in_vld  (S_AXIS_n2k_tvalid),
    .in_rdy  (S_AXIS_n2k_tready),
    .out_dat (out_dat),
    .out_vld (M_AXIS_k2n_tvalid),
    .out_rdy (M_AXIS_k2n_tready)
  );

endmodule

// File: tb/tb_network_interface_pos.sv
// Bench for network_interface_pos: table vectors, hand sequences and a randomized queue scoreboard.
module tb_network_interface_pos;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int TW = 16;

  typedef struct packed {
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;
    logic [TW-1:0] tdest;
  } beat_t;

  typedef struct {
    beat_t src;
    logic  exp_rdy;
    beat_t exp_out;
  } vec_t;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  beat_t         s_beat;
  logic          s_tvalid, s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tlast, m_tready;
  logic [TW-1:0] m_tdest;
  beat_t         m_beat;
  logic [31:0]   number_packets;
  logic          reset_fsm_n, ap_start, ap_idle, ap_done;

  int    checks = 0;
  int    errors = 0;
  beat_t sb_q[$];
  logic  stall_prev = 1'b0;
  beat_t stall_beat;

  always #5 ap_clk = ~ap_clk;

  assign m_beat = {m_tdata, m_tkeep, m_tlast, m_tdest};

  network_interface_pos dut (
    .ap_clk            (ap_clk),
    .ap_rst            (ap_rst),
    .S_AXIS_n2k_tdata  (s_beat.tdata),
    .S_AXIS_n2k_tkeep  (s_beat.tkeep),
    .S_AXIS_n2k_tvalid (s_tvalid),
    .S_AXIS_n2k_tlast  (s_beat.tlast),
    .S_AXIS_n2k_tdest  (s_beat.tdest),
    .S_AXIS_n2k_tready (s_tready),
    .M_AXIS_k2n_tdata  (m_tdata),
    .M_AXIS_k2n_tkeep  (m_tkeep),
    .M_AXIS_k2n_tvalid (m_tvalid),
    .M_AXIS_k2n_tlast  (m_tlast),
    .M_AXIS_k2n_tdest  (m_tdest),
    .M_AXIS_k2n_tready (m_tready),
    .number_packets    (number_packets),
    .reset_fsm_n       (reset_fsm_n),
    .ap_start          (ap_start),
    .ap_idle           (ap_idle),
    .ap_done           (ap_done)
  );

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic beat_t rand_beat(input logic last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.tdata[i*32 +: 32] = $urandom;
    b.tkeep = {$urandom, $urandom};
    b.tlast = last;
    b.tdest = 16'($urandom);
    return b;
  endfunction

  // Reference: outbound stream is exactly the accepted inbound stream, in order, and stalled beats hold.
  always @(negedge ap_clk) begin
    if (ap_rst || !reset_fsm_n) begin
      sb_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_vld", m_tvalid, 1);
        chk("hold_dat", m_beat, stall_beat);
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra outbound beat with nothing accepted, tdata[31:0]=%h", m_tdata[31:0]);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          if (m_beat !== e) begin
            errors++;
            $display("FAIL sb_dat got=%0h want=%0h", m_beat, e);
          end
        end
      end
      if (s_tvalid && s_tready) sb_q.push_back(s_beat);
      stall_prev = m_tvalid && !m_tready;
      stall_beat = m_beat;
    end
  end

  initial begin
    vec_t        tbl[4];
    beat_t       bp[5];
    logic [31:0] bp_w[5];
    logic [31:0] got[$];
    int          idx, out_cnt, pulses, first;
    logic        fire_in, hit_prev, done_prev, accepted;

    ap_rst = 1'b1; reset_fsm_n = 1'b1; ap_start = 1'b0; number_packets = '0;
    s_tvalid = 1'b0; s_beat = '0; m_tready = 1'b0;

    // ---- reset state and IDLE refusal ----
    repeat (3) tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_srdy", s_tready, 0);
    chk("rst_mvld", m_tvalid, 0);
    chk("rst_mdat", m_beat, 0);
    tick();
    s_beat = rand_beat(1'b1); s_tvalid = 1'b1; m_tready = 1'b1;
    @(negedge ap_clk);
    chk("idle_srdy", s_tready, 0);
    tick();
    s_tvalid = 1'b0;
    @(negedge ap_clk);
    chk("idle_mvld", m_tvalid, 0);

    // ---- start ----
    tick();
    number_packets = 32'd10; ap_start = 1'b1;
    @(negedge ap_clk);
    chk("pre_start_idle", ap_idle, 1);
    tick();
    ap_start = 1'b0;
    @(negedge ap_clk);
    chk("start_idle", ap_idle, 0);
    chk("start_srdy", s_tready, 1);

    // ---- table-driven pass-through ----
    tbl[0].src.tdata = {16{32'haaaaaaaa}}; tbl[0].src.tkeep = 64'd100;
    tbl[0].src.tlast = 1'b1;               tbl[0].src.tdest = 16'd10;
    tbl[1].src.tdata = '1;                 tbl[1].src.tkeep = '1;
    tbl[1].src.tlast = 1'b0;               tbl[1].src.tdest = 16'hffff;
    tbl[2].src.tdata = '0;                 tbl[2].src.tkeep = 64'd1;
    tbl[2].src.tlast = 1'b1;               tbl[2].src.tdest = 16'h0000;
    tbl[3].src.tdata = {16{32'h5555aaaa}}; tbl[3].src.tkeep = 64'h8000_0000_0000_0000;
    tbl[3].src.tlast = 1'b0;               tbl[3].src.tdest = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      tbl[i].exp_rdy = 1'b1;
      tbl[i].exp_out = tbl[i].src;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      s_beat = tbl[i].src; s_tvalid = 1'b1;
      @(negedge ap_clk);
      chk("tbl_srdy", s_tready, tbl[i].exp_rdy);
      tick();
      s_tvalid = 1'b0;
      @(negedge ap_clk);
      chk("tbl_mvld", m_tvalid, 1);
      chk("tbl_mdat", m_beat, tbl[i].exp_out);
    end

    // ---- back-pressure: 5-cycle stall with gapped source ----
    bp_w[0] = 32'hbbbbbbbb; bp_w[1] = 32'hcccccccc; bp_w[2] = 32'hdddddddd;
    bp_w[3] = 32'heeeeeeee; bp_w[4] = 32'hffffffff;
    for (int i = 0; i < 5; i++) begin
      bp[i].tdata = {16{bp_w[i]}}; bp[i].tkeep = '1; bp[i].tlast = 1'b0; bp[i].tdest = 16'(i);
    end
    idx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      m_tready = !(cyc >= 1 && cyc <= 5);
      if (idx < 5 && (cyc % 3) != 2) begin
        s_beat = bp[idx]; s_tvalid = 1'b1;
      end else begin
        s_tvalid = 1'b0;
      end
      @(negedge ap_clk);
      if (s_tvalid && s_tready) idx++;
      if (m_tvalid && m_tready) got.push_back(m_tdata[31:0]);
    end
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_seq", got[i], bp_w[i]);

    // ---- soft reset with a beat buffered ----
    tick();
    m_tready = 1'b0; s_beat = rand_beat(1'b1); s_tvalid = 1'b1;
    @(negedge ap_clk);
    chk("sr_accept", s_tready, 1);
    tick();
    s_tvalid = 1'b0;
    @(negedge ap_clk);
    chk("sr_buffered", m_tvalid, 1);
    tick();
    reset_fsm_n = 1'b0;
    @(negedge ap_clk);
    tick();
    reset_fsm_n = 1'b1;
    @(negedge ap_clk);
    chk("sr_mvld", m_tvalid, 0);
    chk("sr_idle", ap_idle, 1);
    chk("sr_srdy", s_tready, 0);

    // ---- completion after 10 single-beat packets; mid-run ap_start ignored ----
    tick();
    m_tready = 1'b1; number_packets = 32'd10; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    idx = 0; out_cnt = 0; pulses = 0; hit_prev = 1'b0; done_prev = 1'b0;
    s_beat = rand_beat(1'b1); s_tvalid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 3) begin
        ap_start = 1'b1; number_packets = 32'd3;
      end else begin
        ap_start = 1'b0;
      end
      @(negedge ap_clk);
      chk("done_pulse", ap_done, hit_prev);
      if (done_prev) begin
        chk("done_then_idle", ap_idle, 1);
        chk("done_then_srdy", s_tready, 0);
      end
      done_prev = ap_done;
      if (ap_done) pulses++;
      fire_in = s_tvalid && s_tready;
      hit_prev = 1'b0;
      if (m_tvalid && m_tready && m_tlast) begin
        out_cnt++;
        hit_prev = (out_cnt == 10);
      end
      tick();
      if (fire_in) begin
        idx++;
        if (idx < 10) s_beat = rand_beat(1'b1);
        else s_tvalid = 1'b0;
      end
    end
    chk("done_pulses", pulses, 1);
    chk("done_pkts_out", out_cnt, 10);

    // ---- number_packets = 0 ----
    number_packets = 32'd0; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    pulses = 0; first = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ap_clk);
      if (ap_done) begin
        pulses++;
        if (first < 0) first = k;
      end
      tick();
    end
    chk("zero_pulses", pulses, 1);
    chk("zero_within_2", (first >= 0 && first <= 1), 1);

    // ---- randomized traffic against the scoreboard ----
    number_packets = 32'hffff_ffff; ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    accepted = 1'b0; s_tvalid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!s_tvalid || accepted) begin
        s_tvalid = ($urandom % 4) != 0;
        s_beat   = rand_beat(1'($urandom % 2));
      end
      m_tready = ($urandom % 3) != 0;
      @(negedge ap_clk);
      accepted = s_tvalid && s_tready;
      tick();
    end
    s_tvalid = 1'b0; m_tready = 1'b1;
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) tick();
    @(negedge ap_clk);
    chk("drain_empty", sb_q.size(), 0);
    chk("drain_mvld", m_tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
